inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h00000000, meaning the PC loaded on reset.
REQ-002 The block SHALL expose ports, one per line, in this order:
  clk  input  1  sole clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  PC  output  32  address of the instruction being fetched
  Inst_Req_Valid  output  1  fetch request to instruction memory
  Inst_Req_Ready  input  1  memory accepts request
  Instruction  input  32  returned instruction word
  Inst_Valid  input  1  memory response valid
  Inst_Ready  output  1  fetch accepts response
  inst_out  output  32  held instruction for decode
  opcode  output  6  inst_out[31:26], feeds control decoder
  funct  output  6  inst_out[5:0], feeds control decoder
  inst_out_valid  output  1  inst_out holds a valid instruction
  inst_out_ready  input  1  decode/execute consumes inst_out this cycle
  redirect_valid  input  1  next PC is redirect_pc (taken branch/jump)
  redirect_pc  input  32  branch/jump target
  pc_plus4  output  32  PC + 4, for link address and sequential path
  fetch_cnt  output  32  instructions delivered (perf)
  stall_cnt  output  32  cycles spent waiting on memory (perf)

Function
REQ-003 The block SHALL be a three-state FSM: REQ, WAIT, HOLD.
REQ-004 REQ: Inst_Req_Valid=1; on Inst_Req_Ready=1 go to WAIT, else stay.
REQ-005 WAIT: Inst_Ready=1; on Inst_Valid=1 capture Instruction into inst_out and go to HOLD, else stay.
REQ-006 HOLD: inst_out_valid=1; on inst_out_ready=1 update PC and go to REQ, else stay with inst_out and PC stable.
REQ-007 Inst_Req_Valid, Inst_Ready and inst_out_valid SHALL be decoded from the current state only (Moore), never from inputs.
REQ-008 PC update in HOLD SHALL be redirect_pc with bits [1:0] forced to 2'b00 when redirect_valid=1, else PC+4; redirect_valid is sampled only in the HOLD consume cycle and ignored otherwise.
REQ-009 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-010 Inst_Valid outside WAIT and Inst_Req_Ready outside REQ SHALL be ignored.
REQ-011 Request-accept and response SHALL take at least one cycle each: Inst_Valid in the same cycle as request acceptance is not captured.
REQ-012 Minimum latency: request accepted cycle N, response cycle N+1, inst_out_valid cycle N+2.
REQ-013 PC and pc_plus4 SHALL remain constant from entry to REQ until the HOLD consume edge.
REQ-014 opcode and funct SHALL be combinational slices of inst_out.

Reset
REQ-015 On rst_n=0, immediately and without clk: state=REQ, PC=RESET_PC, inst_out=32'h0, fetch_cnt=0, stall_cnt=0.
REQ-016 During reset: Inst_Req_Valid=1 after state settles, Inst_Ready=0, inst_out_valid=0, pc_plus4=RESET_PC+4.
REQ-017 Reset asserted in WAIT or HOLD SHALL abandon the outstanding fetch; a late Inst_Valid after release is ignored (state is REQ).
REQ-018 Reset release SHALL take effect on the first rising clk after rst_n=1.

Configuration
REQ-019 Macro INST_FETCH_PERF_CNT_EN SHALL gate performance counters.
REQ-020 Defined: fetch_cnt increments by 1 on each HOLD consume; stall_cnt increments each cycle in REQ with Inst_Req_Ready=0 or in WAIT with Inst_Valid=0; both wrap at 2^32.
REQ-021 Undefined: fetch_cnt and stall_cnt are constant 32'h0 and no counter flops exist; all other behaviour identical.

Verification
REQ-022 Reset with RESET_PC=0, memory always ready/valid next cycle -> PC 0,4,8 on successive fetches, inst_out_valid every 3rd cycle with inst_out_ready=1.
REQ-023 Inst_Req_Ready held 0 for 5 cycles, then 1 -> Inst_Req_Valid high throughout, PC unchanged, stall_cnt=5 (macro on).
REQ-024 HOLD with inst_out=32'h0800_0010, redirect_valid=1, redirect_pc=32'h0000_0043 -> next PC=32'h0000_0040; opcode=6'b000010.
REQ-025 PC=32'hFFFF_FFFC, consume with redirect_valid=0 -> PC=32'h0000_0000, pc_plus4=32'h0000_0004.
REQ-026 rst_n pulsed low mid-WAIT, Inst_Valid=1 one cycle after release -> response ignored, state REQ, PC=RESET_PC, fetch_cnt=0.
REQ-027 Macro undefined, run REQ-022 for 10 instructions -> fetch_cnt and stall_cnt remain 32'h0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: REQ -> WAIT -> HOLD handshake FSM with a held decode buffer.
// Optional performance counters are built only when INST_FETCH_PERF_CNT_EN is defined.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic [31:0] Instruction,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  output logic [31:0] inst_out,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        inst_out_valid,
  input  logic        inst_out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Request side is Inst_Req_Valid/Inst_Req_Ready, response side Inst_Valid/Inst_Ready,
  // decode side inst_out_valid/inst_out_ready. All valids/readies driven here are Moore.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_aligned;
  logic [31:0] w_next_pc;
  logic        w_capture;
  logic        w_consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_REQ:   if (Inst_Req_Ready) w_next_state = S_WAIT;
      S_WAIT:  if (Inst_Valid)     w_next_state = S_HOLD;
      S_HOLD:  if (inst_out_ready) w_next_state = S_REQ;
      default: w_next_state = S_REQ;
    endcase
  end

  assign Inst_Req_Valid = (r_state == S_REQ);
  assign Inst_Ready     = (r_state == S_WAIT);
  assign inst_out_valid = (r_state == S_HOLD);

  assign w_capture = (r_state == S_WAIT) && Inst_Valid;
  assign w_consume = (r_state == S_HOLD) && inst_out_ready;

  // Redirect targets are word aligned; low bits are dropped rather than trapped.
  assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_plus4         = r_pc + 32'd4;
  assign w_next_pc          = redirect_valid ? w_redirect_aligned : w_pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_consume) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst <= 32'h0;
    end else if (w_capture) begin
      r_inst <= Instruction;
    end
  end

  assign PC       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign inst_out = r_inst;
  assign opcode   = r_inst[31:26];
  assign funct    = r_inst[5:0];

`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  // A stall is any cycle the memory side holds us in REQ or WAIT.
  assign w_stall = ((r_state == S_REQ)  && !Inst_Req_Ready) ||
                   ((r_state == S_WAIT) && !Inst_Valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else begin
      if (w_consume) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall)   r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign fetch_cnt = 32'h0;
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, sequential fetch, stalls, redirect, wrap, mid-fetch reset.
// Counter expectations follow INST_FETCH_PERF_CNT_EN as compiled.
module tb_inst_fetch;

`ifdef INST_FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] inst_out;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        inst_out_valid;
  logic        inst_out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic [31:0] exp_stall;
  logic [31:0] exp_q[$];

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC),
    .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .inst_out(inst_out), .opcode(opcode), .funct(funct),
    .inst_out_valid(inst_out_valid), .inst_out_ready(inst_out_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_plus4(pc_plus4), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Inst_Req_Ready = 1'b0;
    Inst_Valid     = 1'b0;
    inst_out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  // driver: one complete fetch from REQ back to REQ with memory always ready
  task automatic do_fetch(input logic [31:0] instr, input logic rv, input logic [31:0] rpc);
    idle_inputs();
    Inst_Req_Ready = 1'b1;
    tick();
    Inst_Req_Ready = 1'b0;
    Instruction    = instr;
    Inst_Valid     = 1'b1;
    tick();
    Inst_Valid     = 1'b0;
    inst_out_ready = 1'b1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    tick();
    idle_inputs();
    exp_pc    = rv ? (rpc & 32'hFFFF_FFFC) : exp_pc + 32'd4;
    exp_fetch = exp_fetch + 32'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    Instruction = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", PC, 32'h0); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc_plus4 got=%h want=%h", pc_plus4, 32'h4); end
    total++; if (Inst_Req_Valid !== 1'b1) begin bad++; $display("FAIL reset_req_valid got=%b want=1", Inst_Req_Valid); end
    total++; if (Inst_Ready !== 1'b0) begin bad++; $display("FAIL reset_inst_ready got=%b want=0", Inst_Ready); end
    total++; if (inst_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", inst_out_valid); end
    total++; if (inst_out !== 32'h0) begin bad++; $display("FAIL reset_inst_out got=%h want=0", inst_out); end
    total++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
      bad++; $display("FAIL reset_counters got=%h/%h want=0/0", fetch_cnt, stall_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    exp_pc = 32'h0; exp_fetch = 32'h0; exp_stall = 32'h0;
  endtask

  task automatic test_seq();
    Inst_Req_Ready = 1'b1;
    Inst_Valid     = 1'b1;
    inst_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Instruction = 32'h1000_0000 + 32'(i);
      exp_q.push_back(Instruction);
      total++; if (PC !== 32'(4 * i) || Inst_Req_Valid !== 1'b1 || inst_out_valid !== 1'b0) begin
        bad++; $display("FAIL seq_req[%0d] pc=%h rv=%b ov=%b want pc=%h rv=1 ov=0", i, PC, Inst_Req_Valid, inst_out_valid, 32'(4 * i));
      end
      tick();
      total++; if (Inst_Ready !== 1'b1 || inst_out_valid !== 1'b0) begin
        bad++; $display("FAIL seq_wait[%0d] ir=%b ov=%b want ir=1 ov=0", i, Inst_Ready, inst_out_valid);
      end
      tick();
      total++; if (inst_out_valid !== 1'b1 || inst_out !== exp_q[0]) begin
        bad++; $display("FAIL seq_hold[%0d] ov=%b inst=%h want ov=1 inst=%h", i, inst_out_valid, inst_out, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
      exp_pc = exp_pc + 32'd4;
      exp_fetch = exp_fetch + 32'd1;
    end
    idle_inputs();
    total++; if (PC !== 32'hC || fetch_cnt !== (PERF ? exp_fetch : 32'h0) || stall_cnt !== 32'h0) begin
      bad++; $display("FAIL seq_end pc=%h fc=%h sc=%h want pc=c fc=%h sc=0", PC, fetch_cnt, stall_cnt, PERF ? exp_fetch : 32'h0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    logic ok;
    idle_inputs();
    Inst_Valid = 1'b1;  // ignored outside WAIT
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_stall = exp_stall + 32'd1;
      if (Inst_Req_Valid !== 1'b1 || PC !== exp_pc || Inst_Ready !== 1'b0 || inst_out_valid !== 1'b0) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL req_stall_hold pc=%h rv=%b want pc=%h rv=1", PC, Inst_Req_Valid, exp_pc); end
    total++; if (stall_cnt !== (PERF ? exp_stall : 32'h0)) begin
      bad++; $display("FAIL req_stall_cnt got=%h want=%h", stall_cnt, PERF ? exp_stall : 32'h0);
    end
    Inst_Req_Ready = 1'b1;
    Instruction    = 32'hDEAD_BEEF;  // valid in the accept cycle must not be captured
    tick();
    Inst_Req_Ready = 1'b0;
    Inst_Valid     = 1'b0;
    total++; if (Inst_Ready !== 1'b1 || inst_out_valid !== 1'b0) begin
      bad++; $display("FAIL accept_no_capture ir=%b ov=%b want ir=1 ov=0", Inst_Ready, inst_out_valid);
    end
    tick(); tick();
    exp_stall = exp_stall + 32'd2;
    Instruction = 32'h2222_3333;
    Inst_Valid  = 1'b1;
    tick();
    Inst_Valid     = 1'b0;
    Inst_Req_Ready = 1'b1;  // ignored in HOLD
    held = PC;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (inst_out_valid !== 1'b1 || inst_out !== 32'h2222_3333 || PC !== exp_pc) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL hold_stable inst=%h pc=%h want inst=22223333 pc=%h", inst_out, held, exp_pc); end
    Inst_Req_Ready = 1'b0;
    inst_out_ready = 1'b1;
    tick();
    idle_inputs();
    exp_pc = exp_pc + 32'd4;
    exp_fetch = exp_fetch + 32'd1;
    total++; if (PC !== exp_pc || stall_cnt !== (PERF ? exp_stall : 32'h0) || fetch_cnt !== (PERF ? exp_fetch : 32'h0)) begin
      bad++; $display("FAIL stall_end pc=%h sc=%h fc=%h want pc=%h sc=%h fc=%h", PC, stall_cnt, fetch_cnt,
                      exp_pc, PERF ? exp_stall : 32'h0, PERF ? exp_fetch : 32'h0);
    end
  endtask

  task automatic test_redirect();
    idle_inputs();
    Inst_Req_Ready = 1'b1;
    tick();
    Inst_Req_Ready = 1'b0;
    Instruction    = 32'h0800_0010;
    Inst_Valid     = 1'b1;
    tick();
    Inst_Valid = 1'b0;
    total++; if (opcode !== 6'b000010 || funct !== 6'b010000) begin
      bad++; $display("FAIL decode_slices op=%b fn=%b want op=000010 fn=010000", opcode, funct);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    inst_out_ready = 1'b1;
    tick();
    idle_inputs();
    exp_pc = 32'h0000_0040;
    exp_fetch = exp_fetch + 32'd1;
    total++; if (PC !== 32'h40 || pc_plus4 !== 32'h44) begin
      bad++; $display("FAIL redirect_pc pc=%h p4=%h want pc=40 p4=44", PC, pc_plus4);
    end
    // redirect outside the consume cycle has no effect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1000;
    tick();
    total++; if (PC !== 32'h40) begin bad++; $display("FAIL redirect_ignored pc=%h want=40", PC); end
    exp_stall = exp_stall + 32'd1;
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_fetch(32'h0000_0001, 1'b1, 32'hFFFF_FFFF);
    total++; if (PC !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      bad++; $display("FAIL wrap_top pc=%h p4=%h want pc=fffffffc p4=0", PC, pc_plus4);
    end
    do_fetch(32'h0000_0002, 1'b0, 32'h0);
    total++; if (PC !== 32'h0 || pc_plus4 !== 32'h4) begin
      bad++; $display("FAIL wrap_zero pc=%h p4=%h want pc=0 p4=4", PC, pc_plus4);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_fetch(32'h0000_0003, 1'b0, 32'h0);
    Inst_Req_Ready = 1'b1;
    tick();
    Inst_Req_Ready = 1'b0;
    total++; if (Inst_Ready !== 1'b1) begin bad++; $display("FAIL pre_reset_wait ir=%b want=1", Inst_Ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (Inst_Ready !== 1'b0 || Inst_Req_Valid !== 1'b1 || PC !== 32'h0) begin
      bad++; $display("FAIL async_reset ir=%b rv=%b pc=%h want ir=0 rv=1 pc=0", Inst_Ready, Inst_Req_Valid, PC);
    end
    tick();
    rst_n = 1'b1;
    exp_pc = 32'h0; exp_fetch = 32'h0; exp_stall = 32'h0;
    tick();
    Instruction = 32'hBAD0_BAD0;
    Inst_Valid  = 1'b1;
    tick();
    Inst_Valid = 1'b0;
    exp_stall = exp_stall + 32'd2;
    total++; if (Inst_Req_Valid !== 1'b1 || Inst_Ready !== 1'b0 || inst_out_valid !== 1'b0 || inst_out !== 32'h0 ||
                 PC !== 32'h0 || fetch_cnt !== 32'h0 || stall_cnt !== (PERF ? exp_stall : 32'h0)) begin
      bad++; $display("FAIL late_valid_ignored rv=%b ir=%b ov=%b inst=%h pc=%h fc=%h sc=%h want rv=1 ir=0 ov=0 inst=0 pc=0 fc=0 sc=%h",
                      Inst_Req_Valid, Inst_Ready, inst_out_valid, inst_out, PC, fetch_cnt, stall_cnt, PERF ? exp_stall : 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) do_fetch(32'(i) << 2, 1'b0, 32'h0);
    total++; if (PC !== 32'd40) begin bad++; $display("FAIL b2b_pc got=%h want=%h", PC, 32'd40); end
    total++; if (fetch_cnt !== (PERF ? exp_fetch : 32'h0) || stall_cnt !== (PERF ? exp_stall : 32'h0)) begin
      bad++; $display("FAIL b2b_counters fc=%h sc=%h want fc=%h sc=%h", fetch_cnt, stall_cnt,
                      PERF ? exp_fetch : 32'h0, PERF ? exp_stall : 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
